// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Optional build macro recognised by fetch_unit: FETCH_MISALIGN_CHK_EN.
package fetch_pkg;

    localparam logic [31:0] FETCH_RESET_PC  = 32'h0000_0000;
    localparam int          FETCH_BUF_DEPTH = 2;
    localparam int          WADDR_W         = 10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

endpackage : fetch_pkg

// File: rtl/fetch_buf.sv
// Small synchronous FIFO of {pc, instruction} entries between fetch and decode.
// Flush empties the queue in one edge; head reads as zero while empty.
module fetch_buf
    import fetch_pkg::*;
#(
    parameter int DEPTH = FETCH_BUF_DEPTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  fetch_entry_t                 push_data,
    input  logic                         pop,
    input  logic                         flush,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output fetch_entry_t                 head
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    fetch_entry_t           mem [DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]       count_q, count_d;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    endfunction

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; count gates every read of it.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr_q] <= push_data;
    end

    assign count = count_q;
    assign head  = (count_q != '0) ? mem[rd_ptr_q] : '0;

endmodule : fetch_buf

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the fetch PC and IDLE/RUN/FAULT control, feeds decode via fetch_buf.
// Define FETCH_MISALIGN_CHK_EN to trap misaligned redirects into a sticky FAULT state.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = FETCH_RESET_PC,
    parameter int          BUF_DEPTH = FETCH_BUF_DEPTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_pc,
    output logic               imem_re,
    output logic [WADDR_W-1:0] imem_raddr,
    input  logic [31:0]        imem_rdata,
    output logic               if_valid,
    input  logic               if_ready,
    output logic [31:0]        if_inst,
    output logic [31:0]        if_pc,
    output logic               if_fault
);

    localparam int CNT_W = $clog2(BUF_DEPTH + 1);

    fetch_state_e     state_q, state_d;
    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [CNT_W-1:0] buf_count;
    fetch_entry_t     buf_head;
    fetch_entry_t     push_entry;
    logic             push, pop, flush;
    logic             fetch_go;

    assign pop        = if_valid && if_ready;
    assign push_entry = '{pc: fetch_pc_q, inst: imem_rdata};

`ifdef FETCH_MISALIGN_CHK_EN
    logic fault_q, fault_d;
`else
    logic unused_redirect_lsbs;
    assign unused_redirect_lsbs = ^redirect_pc[1:0];
`endif

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        flush      = 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
        fault_d    = fault_q;
`endif
        // rst gating keeps imem quiet in the reset cycle even if the state register is in RUN.
        fetch_go = !rst && (state_q == ST_RUN) && !redirect_valid &&
                   ((buf_count < CNT_W'(BUF_DEPTH)) || pop);

        unique case (state_q)
            ST_IDLE: state_d = ST_RUN;
            ST_RUN: begin
                if (redirect_valid) begin
                    flush = 1'b1;
`ifdef FETCH_MISALIGN_CHK_EN
                    if (redirect_pc[1:0] != 2'b00) begin
                        state_d = ST_FAULT;
                        fault_d = 1'b1;
                    end else begin
                        fetch_pc_d = redirect_pc;
                    end
`else
                    fetch_pc_d = {redirect_pc[31:2], 2'b00};
`endif
                end else if (fetch_go) begin
                    fetch_pc_d = fetch_pc_q + 32'd4;
                end
            end
            ST_FAULT: state_d = ST_FAULT;
            default:  state_d = ST_IDLE;
        endcase
    end

    assign push    = fetch_go;
    assign imem_re = fetch_go;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            fetch_pc_q <= RESET_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
        end
    end

`ifdef FETCH_MISALIGN_CHK_EN
    always_ff @(posedge clk) begin
        if (rst) fault_q <= 1'b0;
        else     fault_q <= fault_d;
    end
    assign if_fault = fault_q;
`else
    assign if_fault = 1'b0;
`endif

    fetch_buf #(
        .DEPTH (BUF_DEPTH)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .flush     (flush),
        .count     (buf_count),
        .head      (buf_head)
    );

    assign imem_raddr = fetch_pc_q[11:2];
    assign if_valid   = (buf_count != '0);
    assign if_inst    = buf_head.inst;
    assign if_pc      = buf_head.pc;

endmodule : fetch_unit

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a per-cycle vector table followed by hand-written
// sequences for misaligned redirect, reset mid-operation and word-address wrap.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_re;
    logic [9:0]  imem_raddr;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
    logic        if_fault;

    logic [31:0] mem [1024];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign imem_rdata = imem_re ? mem[imem_raddr] : 32'h0;

    fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_re        (imem_re),
        .imem_raddr     (imem_raddr),
        .imem_rdata     (imem_rdata),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_inst        (if_inst),
        .if_pc          (if_pc),
        .if_fault       (if_fault)
    );

    typedef struct {
        logic        rst;
        logic        rv;
        logic [31:0] rpc;
        logic        rdy;
        logic        exp_re;
        logic [9:0]  exp_raddr;
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic [31:0] exp_inst;
    } vec_t;

    vec_t vecs [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive inputs just after the falling edge, then let combinational outputs settle.
    task automatic cyc(input logic r, input logic rv, input logic [31:0] rpc, input logic rdy);
        @(negedge clk);
        rst            = r;
        redirect_valid = rv;
        redirect_pc    = rpc;
        if_ready       = rdy;
        #1;
    endtask

    task automatic check_out(input string tag, input logic re, input logic [9:0] raddr,
                             input logic valid, input logic [31:0] pc,
                             input logic [31:0] inst, input logic fault);
        check({tag, ".imem_re"},    32'(imem_re),    32'(re));
        check({tag, ".imem_raddr"}, 32'(imem_raddr), 32'(raddr));
        check({tag, ".if_valid"},   32'(if_valid),   32'(valid));
        check({tag, ".if_pc"},      if_pc,           pc);
        check({tag, ".if_inst"},    if_inst,         inst);
        check({tag, ".if_fault"},   32'(if_fault),   32'(fault));
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'hA000_0000 + 32'(i);

        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        if_ready       = 1'b1;

        //            rst   rv    rpc           rdy   re    raddr   valid pc            inst
        vecs[0]  = '{1'b1, 1'b0, 32'h0,       1'b1, 1'b0, 10'h0,  1'b0, 32'h0,        32'h0};
        vecs[1]  = '{1'b1, 1'b0, 32'h0,       1'b1, 1'b0, 10'h0,  1'b0, 32'h0,        32'h0};
        vecs[2]  = '{1'b0, 1'b0, 32'h0,       1'b1, 1'b0, 10'h0,  1'b0, 32'h0,        32'h0};
        vecs[3]  = '{1'b0, 1'b0, 32'h0,       1'b1, 1'b1, 10'h0,  1'b0, 32'h0,        32'h0};
        vecs[4]  = '{1'b0, 1'b0, 32'h0,       1'b0, 1'b1, 10'h1,  1'b1, 32'h0,        32'hA000_0000};
        vecs[5]  = '{1'b0, 1'b0, 32'h0,       1'b0, 1'b0, 10'h2,  1'b1, 32'h0,        32'hA000_0000};
        vecs[6]  = '{1'b0, 1'b0, 32'h0,       1'b0, 1'b0, 10'h2,  1'b1, 32'h0,        32'hA000_0000};
        vecs[7]  = '{1'b0, 1'b0, 32'h0,       1'b0, 1'b0, 10'h2,  1'b1, 32'h0,        32'hA000_0000};
        vecs[8]  = '{1'b0, 1'b0, 32'h0,       1'b0, 1'b0, 10'h2,  1'b1, 32'h0,        32'hA000_0000};
        vecs[9]  = '{1'b0, 1'b0, 32'h0,       1'b1, 1'b1, 10'h2,  1'b1, 32'h0,        32'hA000_0000};
        vecs[10] = '{1'b0, 1'b0, 32'h0,       1'b1, 1'b1, 10'h3,  1'b1, 32'h4,        32'hA000_0001};
        vecs[11] = '{1'b0, 1'b0, 32'h0,       1'b0, 1'b0, 10'h4,  1'b1, 32'h8,        32'hA000_0002};
        vecs[12] = '{1'b0, 1'b1, 32'h100,     1'b0, 1'b0, 10'h4,  1'b1, 32'h8,        32'hA000_0002};
        vecs[13] = '{1'b0, 1'b0, 32'h0,       1'b1, 1'b1, 10'h40, 1'b0, 32'h0,        32'h0};
        vecs[14] = '{1'b0, 1'b0, 32'h0,       1'b1, 1'b1, 10'h41, 1'b1, 32'h100,      32'hA000_0040};
        vecs[15] = '{1'b0, 1'b0, 32'h0,       1'b1, 1'b1, 10'h42, 1'b1, 32'h104,      32'hA000_0041};

        for (int i = 0; i < 16; i++) begin
            cyc(vecs[i].rst, vecs[i].rv, vecs[i].rpc, vecs[i].rdy);
            check_out($sformatf("vec%0d", i), vecs[i].exp_re, vecs[i].exp_raddr,
                      vecs[i].exp_valid, vecs[i].exp_pc, vecs[i].exp_inst, 1'b0);
        end

        // Misaligned redirect to 0x102 while 0x108 sits at the head and is accepted.
        cyc(1'b0, 1'b1, 32'h102, 1'b1);
        check_out("mis0", 1'b0, 10'h43, 1'b1, 32'h108, 32'hA000_0042, 1'b0);
`ifdef FETCH_MISALIGN_CHK_EN
        cyc(1'b0, 1'b0, 32'h0, 1'b1);
        check_out("mis1", 1'b0, 10'h43, 1'b0, 32'h0, 32'h0, 1'b1);
        cyc(1'b0, 1'b1, 32'h200, 1'b1);
        check_out("mis2", 1'b0, 10'h43, 1'b0, 32'h0, 32'h0, 1'b1);
        cyc(1'b0, 1'b0, 32'h0, 1'b1);
        check_out("mis3", 1'b0, 10'h43, 1'b0, 32'h0, 32'h0, 1'b1);
`else
        cyc(1'b0, 1'b0, 32'h0, 1'b1);
        check_out("mis1", 1'b1, 10'h40, 1'b0, 32'h0, 32'h0, 1'b0);
        cyc(1'b0, 1'b0, 32'h0, 1'b1);
        check_out("mis2", 1'b1, 10'h41, 1'b1, 32'h100, 32'hA000_0040, 1'b0);
`endif

        // Reset, then fill the buffer with decode stalled.
        cyc(1'b1, 1'b0, 32'h0, 1'b0);
        check("rst0.imem_re", 32'(imem_re), 32'h0);
        cyc(1'b0, 1'b0, 32'h0, 1'b0);
        check_out("rst1", 1'b0, 10'h0, 1'b0, 32'h0, 32'h0, 1'b0);
        cyc(1'b0, 1'b0, 32'h0, 1'b0);
        check_out("rst2", 1'b1, 10'h0, 1'b0, 32'h0, 32'h0, 1'b0);
        cyc(1'b0, 1'b0, 32'h0, 1'b0);
        check_out("rst3", 1'b1, 10'h1, 1'b1, 32'h0, 32'hA000_0000, 1'b0);
        cyc(1'b0, 1'b0, 32'h0, 1'b0);
        check_out("rst4", 1'b0, 10'h2, 1'b1, 32'h0, 32'hA000_0000, 1'b0);

        // Reset with a full buffer and a concurrent redirect: reset wins.
        cyc(1'b1, 1'b1, 32'h200, 1'b1);
        check("rstfull.imem_re", 32'(imem_re), 32'h0);
        cyc(1'b0, 1'b0, 32'h0, 1'b1);
        check_out("rstfull1", 1'b0, 10'h0, 1'b0, 32'h0, 32'h0, 1'b0);
        cyc(1'b0, 1'b0, 32'h0, 1'b1);
        check_out("rstfull2", 1'b1, 10'h0, 1'b0, 32'h0, 32'h0, 1'b0);
        cyc(1'b0, 1'b0, 32'h0, 1'b1);
        check_out("rstfull3", 1'b1, 10'h1, 1'b1, 32'h0, 32'hA000_0000, 1'b0);

        // Word-address wrap across fetch_pc 0xFFC -> 0x1000.
        cyc(1'b0, 1'b1, 32'hFF8, 1'b1);
        check("wrap0.imem_re", 32'(imem_re), 32'h0);
        cyc(1'b0, 1'b0, 32'h0, 1'b1);
        check_out("wrap1", 1'b1, 10'h3FE, 1'b0, 32'h0, 32'h0, 1'b0);
        cyc(1'b0, 1'b0, 32'h0, 1'b1);
        check_out("wrap2", 1'b1, 10'h3FF, 1'b1, 32'hFF8, 32'hA000_03FE, 1'b0);
        cyc(1'b0, 1'b0, 32'h0, 1'b1);
        check_out("wrap3", 1'b1, 10'h000, 1'b1, 32'hFFC, 32'hA000_03FF, 1'b0);
        cyc(1'b0, 1'b0, 32'h0, 1'b1);
        check_out("wrap4", 1'b1, 10'h001, 1'b1, 32'h1000, 32'hA000_0000, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_fetch_unit

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, byte address of the first fetched instruction after reset.
REQ-002 Parameter BUF_DEPTH, default 2, instruction buffer entries (legal: 2 only).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 redirect_valid  input  1  branch/jump redirect request.
REQ-006 redirect_pc  input  32  redirect target byte address.
REQ-007 imem_re  output  1  instruction memory read enable.
REQ-008 imem_raddr  output  10  instruction memory word address.
REQ-009 imem_rdata  input  32  instruction word; combinational from imem_raddr and imem_re, same cycle.
REQ-010 if_valid  output  1  decode-side instruction available.
REQ-011 if_ready  input  1  decode accepts; transfer when if_valid && if_ready.
REQ-012 if_inst  output  32  instruction at buffer head.
REQ-013 if_pc  output  32  byte PC of if_inst.
REQ-014 if_fault  output  1  misaligned-redirect fault flag (see Configuration).

Function
REQ-015 FSM states IDLE, RUN, FAULT: reset enters IDLE; IDLE->RUN on the first edge with rst low; RUN->FAULT only per REQ-030; FAULT exits only by reset.
REQ-016 32-bit fetch_pc register; imem_raddr = fetch_pc[11:2] at all times.
REQ-017 In RUN, with no redirect_valid and (count < BUF_DEPTH or a pop this cycle): imem_re = 1; at the edge push {fetch_pc, imem_rdata}; fetch_pc += 4.
REQ-018 Otherwise imem_re = 0; no push; fetch_pc holds.
REQ-019 fetch_pc arithmetic is modulo 2^32; imem_raddr wraps 10'h3FF -> 10'h000 (fetch_pc 0xFFC -> 0x1000).
REQ-020 if_valid = (count != 0); if_inst/if_pc driven by head entry; a pop is if_valid && if_ready.
REQ-021 Push and pop in the same cycle leave count unchanged; sustained throughput is one instruction per cycle while if_ready = 1.
REQ-022 With if_ready = 0 and buffer full, imem_re = 0 and if_inst/if_pc hold stable.
REQ-023 redirect_valid in RUN: at the edge clear buffer (count = 0), fetch_pc = redirect_pc; imem_re = 0 that cycle; any concurrent pop still counts as accepted.
REQ-024 After redirect, first fetch is the next cycle; if_valid rises with if_pc = redirect_pc two edges after the redirect edge.
REQ-025 redirect_valid in IDLE or FAULT is ignored.
REQ-026 In IDLE and FAULT: imem_re = 0, no push; in FAULT the buffer drains normally via if_ready.

Reset
REQ-027 On rst: state = IDLE, fetch_pc = RESET_PC, count = 0, buffer pointers = 0, if_fault = 0.
REQ-028 During and immediately after reset: imem_re = 0, if_valid = 0; if_inst = 0, if_pc = 0 while empty.
REQ-029 rst mid-operation overrides redirect, push and pop in the same cycle; first if_valid two edges after the first rst-low edge, if_pc = RESET_PC.

Configuration
REQ-030 Macro FETCH_MISALIGN_CHK_EN defined: redirect_valid with redirect_pc[1:0] != 0 in RUN flushes the buffer, enters FAULT, sets if_fault = 1 (sticky until reset); fetch_pc unchanged.
REQ-031 Macro undefined: if_fault tied 0; redirect_pc[1:0] ignored (fetch_pc = {redirect_pc[31:2], 2'b00}); FAULT unreachable.

Structure
REQ-032 Package fetch_pkg holds RESET_PC default, BUF_DEPTH, word-address width 10, and the FSM state enum.
REQ-033 Sub-module fetch_buf: BUF_DEPTH-entry 64-bit synchronous FIFO with push, pop, flush, count, head outputs; fetch_unit holds FSM and fetch_pc.

Verification
REQ-034 Reset release, RESET_PC = 0, if_ready = 1, mem[i] = 0xA000_0000+i -> if_pc 0,4,8,... with if_inst A000_0000, A000_0001, ... one per cycle, first two edges after release.
REQ-035 if_ready = 0 for 5 cycles after first valid -> count reaches 2, imem_re = 0, if_pc holds 0; release -> 0,4,8 with no gap, no duplicates.
REQ-036 Redirect to 0x100 while buffer holds 0x8, 0xC -> 0x8/0xC never delivered; next delivered if_pc = 0x100, two edges after redirect.
REQ-037 fetch_pc reaches 0xFFC -> imem_raddr 0x3FF then 0x000; if_pc 0xFFC then 0x1000.
REQ-038 Redirect to 0x102: with FETCH_MISALIGN_CHK_EN -> if_fault = 1, imem_re = 0 until rst; without -> fetch resumes at if_pc 0x100.
REQ-039 rst asserted with full buffer and redirect_valid = 1 -> next cycle count = 0, if_valid = 0, fetch_pc = RESET_PC.
